keys_pio_debounce: RTL and testbench

Parametrised Avalon-MM input port for push-buttons and switches, replacing the fixed 3-bit key PIO. It synchronises and debounces `WIDTH` inputs with a run-time threshold. It captures rising and/or falling edges per bit, with per-bit mode selection, and raises a maskable level interrupt to the Nios II. It also keeps a saturating event counter for diagnostics.

---
 rtl/keys_pio_debounce_pkg.sv | 20 ++
 rtl/keys_pio_debounce_if.sv | 12 +
 rtl/keys_pio_debounce_channel.sv | 47 ++++
 rtl/keys_pio_debounce.sv | 96 +++++++++
 tb/tb_keys_pio_debounce.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keys_pio_debounce_pkg.sv
// rtl/keys_pio_debounce_pkg.sv - register map, widths and defaults for the debounced key PIO
package keys_pio_pkg;

  typedef enum logic [2:0] {
    REG_DATA         = 3'd0,
    REG_RAW          = 3'd1,
    REG_IRQ_MASK     = 3'd2,
    REG_EDGE_CAPTURE = 3'd3,
    REG_RISE_EN      = 3'd4,
    REG_FALL_EN      = 3'd5,
    REG_DEBOUNCE     = 3'd6,
    REG_EVENT_CNT    = 3'd7
  } reg_addr_e;

  localparam int          EVT_CNT_W         = 16;
  localparam int          KEYS_DEF_WIDTH    = 4;
  localparam int          KEYS_DEF_CNT_W    = 20;
  localparam int unsigned KEYS_DEF_DEBOUNCE = 500000;

endpackage

// File: rtl/keys_pio_debounce_if.sv
// rtl/keys_pio_debounce_if.sv - Avalon-MM slave bus plus interrupt line of the key PIO
interface keys_pio_debounce_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/keys_pio_debounce_channel.sv
// rtl/keys_pio_debounce_channel.sv - one key: 2-flop synchroniser, debounce counter, level/prev flops
module key_debounce_channel #(
  parameter int   CNT_W      = 20,
  parameter logic INIT_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic [CNT_W-1:0] threshold,
  input  logic             cnt_clear,
  output logic             sync_level,
  output logic             level,
  output logic             level_prev
);

  logic             sync_meta;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             done;

  // A threshold of 0 behaves like 1: accept the new level on the first differing cycle.
  assign last_cnt = (threshold == '0) ? '0 : threshold - CNT_W'(1);
  assign done     = (cnt >= last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta  <= INIT_LEVEL;
      sync_level <= INIT_LEVEL;
      level      <= INIT_LEVEL;
      level_prev <= INIT_LEVEL;
      cnt        <= '0;
    end else begin
      sync_meta  <= din;
      sync_level <= sync_meta;
      level_prev <= level;
      if (cnt_clear || (sync_level == level)) begin
        cnt <= '0;
      end else if (done) begin
        level <= sync_level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/keys_pio_debounce.sv
// rtl/keys_pio_debounce.sv - debounced key PIO: register decode, edge capture, irq, event counter
module keys_pio_debounce
  import keys_pio_pkg::*;
#(
  parameter int               WIDTH        = KEYS_DEF_WIDTH,
  parameter int               CNT_W        = KEYS_DEF_CNT_W,
  parameter int unsigned      DEF_DEBOUNCE = KEYS_DEF_DEBOUNCE,
  parameter logic [WIDTH-1:0] INIT_LEVEL   = '1
) (
  input  logic                clk,
  input  logic                reset,
  keys_pio_debounce_if.slave  bus,
  input  logic [WIDTH-1:0]    in_port
);

  logic [WIDTH-1:0]     sync_v, deb_v, prev_v, evt;
  logic [WIDTH-1:0]     irq_mask, edge_cap, rise_en, fall_en;
  logic [WIDTH-1:0]     wdata_w;
  logic [CNT_W-1:0]     threshold;
  logic [EVT_CNT_W-1:0] evt_cnt;
  logic [31:0]          rd_next;
  logic                 wr_en, wr_thr;
  logic                 unused_wdata;
  reg_addr_e            addr;

  assign addr         = reg_addr_e'(bus.address);
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wr_thr       = wr_en && (addr == REG_DEBOUNCE);
  assign wdata_w      = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_channel #(
      .CNT_W      (CNT_W),
      .INIT_LEVEL (INIT_LEVEL[i])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .din        (in_port[i]),
      .threshold  (threshold),
      .cnt_clear  (wr_thr),
      .sync_level (sync_v[i]),
      .level      (deb_v[i]),
      .level_prev (prev_v[i])
    );
  end

  assign evt     = (~prev_v & deb_v & rise_en) | (prev_v & ~deb_v & fall_en);
  assign bus.irq = |(edge_cap & irq_mask);

  always_comb begin
    rd_next = '0;
    case (addr)
      REG_DATA:         rd_next[WIDTH-1:0]     = deb_v;
      REG_RAW:          rd_next[WIDTH-1:0]     = sync_v;
      REG_IRQ_MASK:     rd_next[WIDTH-1:0]     = irq_mask;
      REG_EDGE_CAPTURE: rd_next[WIDTH-1:0]     = edge_cap;
      REG_RISE_EN:      rd_next[WIDTH-1:0]     = rise_en;
      REG_FALL_EN:      rd_next[WIDTH-1:0]     = fall_en;
      REG_DEBOUNCE:     rd_next[CNT_W-1:0]     = threshold;
      REG_EVENT_CNT:    rd_next[EVT_CNT_W-1:0] = evt_cnt;
      default:          rd_next                = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_cap     <= '0;
      rise_en      <= '0;
      fall_en      <= '1;
      threshold    <= CNT_W'(DEF_DEBOUNCE);
      evt_cnt      <= '0;
      bus.readdata <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          REG_IRQ_MASK: irq_mask  <= wdata_w;
          REG_RISE_EN:  rise_en   <= wdata_w;
          REG_FALL_EN:  fall_en   <= wdata_w;
          REG_DEBOUNCE: threshold <= bus.writedata[CNT_W-1:0];
          default:      ;
        endcase
      end
      // New events are OR-ed in after the W1C so a coincident clear never loses one.
      edge_cap <= ((wr_en && (addr == REG_EDGE_CAPTURE)) ? (edge_cap & ~wdata_w) : edge_cap) | evt;
      if (wr_en && (addr == REG_EVENT_CNT)) begin
        evt_cnt <= (|evt) ? EVT_CNT_W'(1) : '0;
      end else if ((|evt) && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + EVT_CNT_W'(1);
      end
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_keys_pio_debounce.sv
// tb/tb_keys_pio_debounce.sv - self-checking bench for keys_pio_debounce
module tb_keys_pio_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] in_port;
  int         total;
  int         bad;

  keys_pio_debounce_if bif();

  keys_pio_debounce dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bif),
    .in_port (in_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [31:0] exp;
  } rvec_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bif.address    = a;
    bif.writedata  = d;
    bif.chipselect = 1'b1;
    bif.write_n    = 1'b0;
    tick(1);
    bif.chipselect = 1'b0;
    bif.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bif.address    = a;
    bif.chipselect = 1'b1;
    bif.write_n    = 1'b1;
    tick(1);
    d = bif.readdata;
    bif.chipselect = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  // Reference: a bit's debounced level follows once sync has shown the same
  // differing value for the last max(N,1) consecutive cycles.
  task automatic rand_seg(input int n_thr);
    logic [3:0]  pins, deb, cap, rise, fall, ev, dn;
    logic [3:0]  ph[$];
    logic [3:0]  sh[$];
    logic        same;
    int          cnt, win;
    win  = (n_thr == 0) ? 1 : n_thr;
    rise = 4'($urandom);
    fall = 4'($urandom);
    pins = in_port;
    wr(3'd6, 32'(n_thr));
    tick(12);
    wr(3'd4, 32'(rise));
    wr(3'd5, 32'(fall));
    wr(3'd2, 32'hF);
    wr(3'd3, 32'hF);
    wr(3'd7, 32'h0);
    deb = pins; cap = '0; ev = '0; cnt = 0;
    ph.push_back(pins);
    for (int k = 0; k < 8; k++) sh.push_back(pins);
    for (int c = 0; c < 260; c++) begin
      if (c < 240 && $urandom_range(2) == 0) pins[$urandom_range(3)] ^= 1'b1;
      in_port = pins;
      ph.push_back(pins);
      @(posedge clk);
      cap = cap | ev;
      if (ev != 0 && cnt < 65535) cnt++;
      dn = deb;
      for (int b = 0; b < 4; b++) begin
        same = 1'b1;
        for (int k = 1; k <= win; k++)
          if (sh[sh.size()-k][b] != sh[sh.size()-1][b]) same = 1'b0;
        if (same && sh[sh.size()-1][b] != deb[b]) dn[b] = sh[sh.size()-1][b];
      end
      ev  = (~deb & dn & rise) | (deb & ~dn & fall);
      deb = dn;
      sh.push_back(ph[ph.size()-2]);
      #1;
      check("rand_irq", {31'b0, bif.irq}, {31'b0, |cap});
    end
    rd_check("rand_data", 3'd0, 32'(deb));
    rd_check("rand_raw", 3'd1, 32'(pins));
    rd_check("rand_capture", 3'd3, 32'(cap));
    rd_check("rand_evt_cnt", 3'd7, 32'(cnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rvec_t tbl[8];
    logic [31:0] d;
    total = 0;
    bad   = 0;
    tbl[0] = '{"rst_data",      3'd0, 32'hF};
    tbl[1] = '{"rst_raw",       3'd1, 32'hF};
    tbl[2] = '{"rst_irq_mask",  3'd2, 32'h0};
    tbl[3] = '{"rst_capture",   3'd3, 32'h0};
    tbl[4] = '{"rst_rise_en",   3'd4, 32'h0};
    tbl[5] = '{"rst_fall_en",   3'd5, 32'hF};
    tbl[6] = '{"rst_debounce",  3'd6, 32'd500000};
    tbl[7] = '{"rst_evt_cnt",   3'd7, 32'h0};

    reset = 1'b1;
    in_port = 4'hF;
    bif.address = '0; bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.writedata = '0;
    tick(3);
    check("in_reset_readdata", bif.readdata, 32'h0);
    check("in_reset_irq", {31'b0, bif.irq}, 32'h0);
    reset = 1'b0;
    tick(2);

    // Test 1: reset state of every register
    for (int i = 0; i < 8; i++) rd_check(tbl[i].name, tbl[i].addr, tbl[i].exp);
    check("rst_irq", {31'b0, bif.irq}, 32'h0);

    // Test 2: short glitch rejected, then full debounce latency
    wr(3'd6, 32'd8);
    wr(3'd2, 32'h1);
    in_port[0] = 1'b0; tick(5);
    in_port[0] = 1'b1; tick(15);
    rd_check("glitch_data", 3'd0, 32'hF);
    rd_check("glitch_capture", 3'd3, 32'h0);
    bif.address = 3'd0; bif.chipselect = 1'b1; bif.write_n = 1'b1;
    in_port[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 10) begin
        check("lat_data_before", bif.readdata, 32'hF);
        check("lat_irq_before", {31'b0, bif.irq}, 32'h0);
      end
      if (k == 11) begin
        check("lat_data_after", bif.readdata, 32'hE);
        check("lat_irq_after", {31'b0, bif.irq}, 32'h1);
      end
    end
    bif.chipselect = 1'b0;
    tick(8);
    rd_check("fall_capture", 3'd3, 32'h1);
    rd_check("fall_evt_cnt", 3'd7, 32'h1);

    // Test 3: W1C clear, then clear coinciding with a new event
    wr(3'd3, 32'h1);
    check("w1c_irq", {31'b0, bif.irq}, 32'h0);
    in_port[0] = 1'b1; tick(14);
    in_port[0] = 1'b0; tick(10);
    wr(3'd3, 32'h1);
    rd_check("set_wins_capture", 3'd3, 32'h1);
    rd_check("set_wins_evt_cnt", 3'd7, 32'h2);

    // Test 4: rise-only mode on bit 1, masked
    wr(3'd6, 32'd1);
    wr(3'd4, 32'h2);
    wr(3'd5, 32'h0);
    wr(3'd2, 32'h0);
    wr(3'd3, 32'hF);
    in_port[1] = 1'b0; tick(8);
    rd_check("rise_only_fall", 3'd3, 32'h0);
    in_port[1] = 1'b1; tick(8);
    rd_check("rise_only_rise", 3'd3, 32'h2);
    check("masked_irq", {31'b0, bif.irq}, 32'h0);
    rd_check("rise_evt_cnt", 3'd7, 32'h3);

    // Test 5: event counter saturation and clear
    wr(3'd4, 32'hF);
    wr(3'd5, 32'hF);
    for (int k = 0; k < 65540; k++) begin
      in_port[2] = ~in_port[2];
      tick(1);
    end
    tick(6);
    rd_check("evt_cnt_sat", 3'd7, 32'hFFFF);
    wr(3'd7, 32'h0);
    rd_check("evt_cnt_clear", 3'd7, 32'h0);
    in_port[2] = ~in_port[2];
    tick(3);
    wr(3'd7, 32'h0);
    rd_check("evt_cnt_clear_evt", 3'd7, 32'h1);

    // Randomised segments against the reference model
    for (int s = 0; s < 4; s++) rand_seg($urandom_range(5));

    // Test 6: reset in the middle of a debounce
    wr(3'd6, 32'd1);
    in_port = 4'hF; tick(10);
    wr(3'd5, 32'hF);
    wr(3'd2, 32'hF);
    wr(3'd3, 32'hF);
    in_port[3] = 1'b0; tick(6);
    check("pre_reset_irq", {31'b0, bif.irq}, 32'h1);
    wr(3'd6, 32'd8);
    in_port[0] = 1'b0; tick(6);
    reset = 1'b1;
    #1;
    check("async_reset_irq", {31'b0, bif.irq}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(20);
    rd_check("post_reset_data", 3'd0, 32'hF);
    rd_check("post_reset_raw", 3'd1, 32'h6);
    rd_check("post_reset_capture", 3'd3, 32'h0);
    check("post_reset_irq", {31'b0, bif.irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
